// File: rtl/bullet_scheduler.sv
// Player bullet scheduler: latches fire presses, spawns bullets into the lowest free
// slot on frame ticks subject to a cooldown, and moves/retires bullets in flight.
//
// state | meaning
// FREE  | slot idle, x/y hold last values
// FLY   | bullet in flight, moves up BULL_V per frame_tick
module bullet_scheduler #(
   parameter int NSLOT     = 4,
   parameter int BULL_T    = 464,
   parameter int BULL_V    = 2,
   parameter int TOP_LIMIT = 10,
   parameter int X_OFF     = 3,
   parameter int COOLDOWN  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_tick,
   input  logic                 fire_n,
   input  logic [10:0]          ship_x,
   input  logic [NSLOT-1:0]     hit,
   output logic [NSLOT-1:0]     slot_active,
   output logic [11*NSLOT-1:0]  bull_x,
   output logic [11*NSLOT-1:0]  bull_y,
   output logic                 fire_grant,
   output logic                 fire_drop,
   output logic                 cooldown_busy
);

   localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

   typedef enum logic {FREE = 1'b0, FLY = 1'b1} slot_state_t;

   slot_state_t       state_q [NSLOT];
   slot_state_t       state_d [NSLOT];
   logic [10:0]       x_q [NSLOT];
   logic [10:0]       x_d [NSLOT];
   logic [10:0]       y_q [NSLOT];
   logic [10:0]       y_d [NSLOT];
   logic              fire_prev;
   logic              pending, pending_d;
   logic [CW-1:0]     cooldown, cooldown_d;
   logic              press, alloc, drop, any_free;
   logic [NSLOT-1:0]  alloc_vec;

   always_comb begin
      press     = fire_prev & ~fire_n;
      alloc_vec = '0;
      any_free  = 1'b0;
      // Eligibility uses registered state, so slots retiring this cycle are not candidates
      for (int i = 0; i < NSLOT; i++) begin
         if (state_q[i] == FREE && !any_free) begin
            alloc_vec[i] = 1'b1;
            any_free     = 1'b1;
         end
      end
      alloc = frame_tick && pending && (cooldown == '0) && any_free;
      drop  = frame_tick && pending && (cooldown == '0) && !any_free;

      pending_d = pending;
      if (alloc || drop)
         pending_d = 1'b0;
      else if (press)
         pending_d = 1'b1;

      cooldown_d = cooldown;
      if (alloc)
         cooldown_d = CW'(COOLDOWN);
      else if (frame_tick && cooldown != '0)
         cooldown_d = cooldown - 1'b1;

      for (int i = 0; i < NSLOT; i++) begin
         state_d[i] = state_q[i];
         x_d[i]     = x_q[i];
         y_d[i]     = y_q[i];
         case (state_q[i])
            FREE: begin
               if (alloc && alloc_vec[i]) begin
                  state_d[i] = FLY;
                  x_d[i]     = ship_x + 11'(X_OFF);
                  y_d[i]     = 11'(BULL_T);
               end
            end
            FLY: begin
               if (hit[i])
                  state_d[i] = FREE;
               else if (frame_tick) begin
                  if (y_q[i] <= 11'(TOP_LIMIT))
                     state_d[i] = FREE;
                  else
                     y_d[i] = y_q[i] - 11'(BULL_V);
               end
            end
            default: state_d[i] = FREE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NSLOT; i++) begin
            state_q[i] <= FREE;
            x_q[i]     <= '0;
            y_q[i]     <= 11'(BULL_T);
         end
         fire_prev     <= 1'b0;
         pending       <= 1'b0;
         cooldown      <= '0;
         fire_grant    <= 1'b0;
         fire_drop     <= 1'b0;
         cooldown_busy <= 1'b0;
      end else begin
         for (int i = 0; i < NSLOT; i++) begin
            state_q[i] <= state_d[i];
            x_q[i]     <= x_d[i];
            y_q[i]     <= y_d[i];
         end
         fire_prev     <= fire_n;
         pending       <= pending_d;
         cooldown      <= cooldown_d;
         fire_grant    <= alloc;
         fire_drop     <= drop;
         cooldown_busy <= (cooldown_d != '0);
      end
   end

   always_comb begin
      for (int i = 0; i < NSLOT; i++) begin
         slot_active[i]     = (state_q[i] == FLY);
         bull_x[11*i +: 11] = x_q[i];
         bull_y[11*i +: 11] = y_q[i];
      end
   end

endmodule
